// File: rtl/conv_peak_stream.sv
// rtl/conv_peak_stream.sv - symmetric FIR over a pixel line, reports peak score and position
module conv_peak_stream #(
  parameter int LINE_LEN = 120,
  parameter int TAPS     = 16,
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 8,
  localparam int ACC_W   = PIX_W + COEF_W + $clog2(TAPS),
  localparam int POS_W   = $clog2(LINE_LEN)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pix_valid,
  input  logic                       pix_sol,
  input  logic [PIX_W-1:0]           pix_data,
  input  logic [TAPS/2*COEF_W-1:0]   coef,
  input  logic [ACC_W-1:0]           threshold,
  input  logic                       res_ready,
  output logic                       res_valid,
  output logic [ACC_W-1:0]           res_maxval,
  output logic [POS_W-1:0]           res_maxpos,
  output logic                       res_found,
  output logic                       res_overrun
);

  localparam logic [POS_W-1:0] LAST_TAP = POS_W'(TAPS - 1);
  localparam logic [POS_W-1:0] LAST_PIX = POS_W'(LINE_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  // Kernel is stored as one half; tap k mirrors onto coefficient min(k, TAPS-1-k).
  function automatic int half_idx(input int k);
    return (k < TAPS - 1 - k) ? k : TAPS - 1 - k;
  endfunction

  state_t                     state;
  logic [POS_W-1:0]           cnt;
  logic [PIX_W-1:0]           win [TAPS];
  logic [PIX_W-1:0]           win_nx [TAPS];
  logic [TAPS/2*COEF_W-1:0]   coef_q;
  logic [ACC_W-1:0]           thr_q;

  logic                       take;
  logic [POS_W-1:0]           pos;
  logic                       emit;
  logic [ACC_W-1:0]           score;

  logic                       s1_valid;
  logic                       s1_first;
  logic                       s1_last;
  logic [ACC_W-1:0]           s1_score;
  logic [POS_W-1:0]           s1_pos;

  logic [ACC_W-1:0]           max_val;
  logic [POS_W-1:0]           max_pos;
  logic                       upd;
  logic [ACC_W-1:0]           cur_val;
  logic [POS_W-1:0]           cur_pos;

  // A pixel is consumed when it starts a line or continues one in progress;
  // stray non-sol pixels in IDLE/DONE are dropped.
  assign take = pix_valid && (pix_sol || state == FILL || state == RUN);
  assign pos  = pix_sol ? '0 : cnt;
  assign emit = take && (pos >= LAST_TAP);

  // Window as it will look after this pixel shifts in (index 0 = oldest).
  always_comb begin
    for (int k = 0; k < TAPS - 1; k++) begin
      win_nx[k] = win[k+1];
    end
    win_nx[TAPS-1] = pix_data;
  end

  // Full-precision dot product of the incoming window with the mirrored kernel.
  always_comb begin
    score = '0;
    for (int k = 0; k < TAPS; k++) begin
      score = score + ACC_W'(win_nx[k]) * ACC_W'(coef_q[half_idx(k)*COEF_W +: COEF_W]);
    end
  end

  // Line-tracking FSM: state, pixel index, window shift register and per-line latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      coef_q <= '0;
      thr_q  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        win[k] <= '0;
      end
    end else begin
      if (take) begin
        cnt <= pos + 1'b1;
        for (int k = 0; k < TAPS; k++) begin
          win[k] <= win_nx[k];
        end
      end
      if (pix_valid && pix_sol) begin
        coef_q <= coef;
        thr_q  <= threshold;
      end
      case (state)
        IDLE: begin
          if (take) state <= FILL;
        end
        FILL, RUN: begin
          if (take) begin
            if (pix_sol)               state <= FILL;
            else if (pos == LAST_PIX)  state <= DONE;
            else if (pos == LAST_TAP)  state <= RUN;
          end
        end
        DONE: begin
          if (take)                      state <= FILL;
          else if (s1_valid && s1_last)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Score register stage; tags the window with its start index and line-boundary flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_score <= '0;
      s1_pos   <= '0;
    end else begin
      s1_valid <= emit;
      if (emit) begin
        s1_score <= score;
        s1_pos   <= pos - LAST_TAP;
        s1_first <= (pos == LAST_TAP);
        s1_last  <= (pos == LAST_PIX);
      end
    end
  end

  // Window 0 seeds the max, so leftovers from an aborted line never leak forward;
  // strict compare keeps the earliest window on ties.
  assign upd     = s1_valid && (s1_first || (s1_score > max_val));
  assign cur_val = upd ? s1_score : max_val;
  assign cur_pos = upd ? s1_pos   : max_pos;

  // Running-max compare stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_pos <= '0;
    end else if (s1_valid) begin
      max_val <= cur_val;
      max_pos <= cur_pos;
    end
  end

  // Result holding register: load on line completion if free, else drop and flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_maxval  <= '0;
      res_maxpos  <= '0;
      res_found   <= 1'b0;
      res_overrun <= 1'b0;
    end else if (s1_valid && s1_last) begin
      if (!res_valid || res_ready) begin
        res_valid  <= 1'b1;
        res_maxval <= cur_val;
        res_maxpos <= cur_pos;
        res_found  <= (cur_val >= thr_q);
      end else begin
        res_overrun <= 1'b1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_peak_stream.sv
// tb/tb_conv_peak_stream.sv - self-checking bench for conv_peak_stream
module tb_conv_peak_stream;
  localparam int LINE_LEN = 120;
  localparam int TAPS     = 16;
  localparam int PIX_W    = 8;
  localparam int COEF_W   = 8;
  localparam int ACC_W    = 20;
  localparam int POS_W    = 7;
  localparam int CW       = TAPS / 2 * COEF_W;

  localparam logic [CW-1:0] C_ONES = 64'h0101010101010101;
  localparam logic [CW-1:0] C_RAMP = 64'h0807060504030201;
  localparam logic [CW-1:0] C_FF   = 64'hffffffffffffffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_valid = 1'b0;
  logic              pix_sol = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic [CW-1:0]     coef = '0;
  logic [ACC_W-1:0]  threshold = '0;
  logic              res_ready = 1'b0;
  logic              res_valid;
  logic [ACC_W-1:0]  res_maxval;
  logic [POS_W-1:0]  res_maxpos;
  logic              res_found;
  logic              res_overrun;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic [POS_W-1:0] pos;
    logic             found;
  } res_t;

  typedef struct {
    int               kind;
    int               ipos;
    int               ival;
    logic [CW-1:0]    cf;
    logic [ACC_W-1:0] thr;
    bit               use_model;
    bit               gaps;
    res_t             exp;
  } vec_t;

  res_t              exp_q[$];
  logic [PIX_W-1:0]  line_pix [LINE_LEN];
  logic [CW-1:0]     coef_line;
  logic [ACC_W-1:0]  thr_line;
  int                n_vec = 0;
  int                n_err = 0;

  conv_peak_stream #(
    .LINE_LEN (LINE_LEN),
    .TAPS     (TAPS),
    .PIX_W    (PIX_W),
    .COEF_W   (COEF_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_valid   (pix_valid),
    .pix_sol     (pix_sol),
    .pix_data    (pix_data),
    .coef        (coef),
    .threshold   (threshold),
    .res_ready   (res_ready),
    .res_valid   (res_valid),
    .res_maxval  (res_maxval),
    .res_maxpos  (res_maxpos),
    .res_found   (res_found),
    .res_overrun (res_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t mk_res(input int v, input int p, input bit f);
    res_t r;
    r.val   = ACC_W'(v);
    r.pos   = POS_W'(p);
    r.found = f;
    return r;
  endfunction

  function automatic vec_t mk_vec(input int kind, input int ipos, input int ival,
                                  input logic [CW-1:0] cf, input logic [ACC_W-1:0] thr,
                                  input bit use_model, input bit gaps, input res_t e);
    vec_t v;
    v.kind = kind; v.ipos = ipos; v.ival = ival; v.cf = cf; v.thr = thr;
    v.use_model = use_model; v.gaps = gaps; v.exp = e;
    return v;
  endfunction

  // kind 0: single impulse (ival at ipos), 1: constant ival, 2: random
  task automatic fill_line(input int kind, input int ipos, input int ival);
    for (int i = 0; i < LINE_LEN; i++) begin
      case (kind)
        0:       line_pix[i] = (i == ipos) ? PIX_W'(ival) : '0;
        1:       line_pix[i] = PIX_W'(ival);
        default: line_pix[i] = PIX_W'($urandom);
      endcase
    end
  endtask

  // Brute-force reference: every window summed from the raw line.
  function automatic res_t model();
    res_t        r;
    int unsigned s;
    int unsigned best;
    int          bpos;
    best = 0;
    bpos = 0;
    for (int w = 0; w <= LINE_LEN - TAPS; w++) begin
      s = 0;
      for (int k = 0; k < TAPS; k++) begin
        int ci;
        ci = (k <= TAPS - 1 - k) ? k : TAPS - 1 - k;
        s += 32'(line_pix[w+k]) * 32'(coef_line[ci*COEF_W +: COEF_W]);
      end
      if (w == 0 || s > best) begin
        best = s;
        bpos = w;
      end
    end
    r.val   = ACC_W'(best);
    r.pos   = POS_W'(bpos);
    r.found = (best >= 32'(thr_line));
    return r;
  endfunction

  task automatic send_line(input bit push, input res_t e, input int n_pix, input bit gaps);
    coef      = coef_line;
    threshold = thr_line;
    for (int i = 0; i < n_pix; i++) begin
      if (gaps && i > 0 && $urandom_range(3) == 0) begin
        pix_valid = 1'b0;
        pix_sol   = 1'b1;
        pix_data  = PIX_W'($urandom);
        tick();
      end
      pix_valid = 1'b1;
      pix_sol   = (i == 0);
      pix_data  = line_pix[i];
      tick();
      if (i == 0) begin
        coef      = {$urandom, $urandom};
        threshold = ACC_W'($urandom);
      end
    end
    pix_valid = 1'b0;
    pix_sol   = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  task automatic junk(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_sol   = 1'b0;
      pix_data  = 8'hff;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic check_latency(input string name);
    @(negedge clk);
    chk({name, "_lat1"}, 64'(res_valid), 64'd0);
    @(negedge clk);
    chk({name, "_lat2"}, 64'(res_valid), 64'd1);
    tick();
    tick();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_valid"},   64'(res_valid),   64'd0);
    chk({name, "_maxval"},  64'(res_maxval),  64'd0);
    chk({name, "_maxpos"},  64'(res_maxpos),  64'd0);
    chk({name, "_found"},   64'(res_found),   64'd0);
    chk({name, "_overrun"}, 64'(res_overrun), 64'd0);
  endtask

  // Scoreboard: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    res_t e;
    if (rst_n && res_valid && res_ready) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 64'({res_maxval, res_maxpos, res_found}), 64'(e));
      end
    end
  end

  initial begin
    vec_t tv[10];
    res_t e;

    tv[0] = mk_vec(0, -1,  0,  C_ONES, 20'd1,       0, 0, mk_res(0, 0, 0));
    tv[1] = mk_vec(0, 50,  255, C_ONES, 20'd1,      0, 0, mk_res(255, 35, 1));
    tv[2] = mk_vec(0, 60,  10, C_RAMP, 20'd80,      0, 0, mk_res(80, 52, 1));
    tv[3] = mk_vec(0, 60,  10, C_RAMP, 20'd81,      0, 0, mk_res(80, 52, 0));
    tv[4] = mk_vec(1, 0,   255, C_FF,  20'd1040400, 0, 0, mk_res(1040400, 0, 1));
    tv[5] = mk_vec(0, 0,   200, C_RAMP, 20'd0,      0, 0, mk_res(200, 0, 1));
    tv[6] = mk_vec(0, 119, 3,  C_RAMP, 20'd3,       0, 0, mk_res(3, 104, 1));
    tv[7] = mk_vec(2, 0, 0, {$urandom, $urandom}, ACC_W'($urandom_range(150000, 350000)), 1, 1, mk_res(0, 0, 0));
    tv[8] = mk_vec(2, 0, 0, {$urandom, $urandom}, ACC_W'($urandom_range(150000, 350000)), 1, 1, mk_res(0, 0, 0));
    tv[9] = mk_vec(2, 0, 0, C_RAMP, 20'd0, 1, 1, mk_res(0, 0, 0));

    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk_outputs_zero("reset");
    tick();
    rst_n     = 1'b1;
    res_ready = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      coef_line = tv[i].cf;
      thr_line  = tv[i].thr;
      fill_line(tv[i].kind, tv[i].ipos, tv[i].ival);
      if (tv[i].use_model) tv[i].exp = model();
      junk(3);
      send_line(1'b1, tv[i].exp, LINE_LEN, tv[i].gaps);
      check_latency($sformatf("row%0d", i));
    end

    // Two lines back-to-back while the consumer stalls.
    res_ready = 1'b0;
    coef_line = C_RAMP;
    thr_line  = 20'd80;
    fill_line(0, 60, 10);
    send_line(1'b1, mk_res(80, 52, 1), LINE_LEN, 0);
    coef_line = {$urandom, $urandom};
    thr_line  = 20'd0;
    fill_line(2, 0, 0);
    send_line(1'b0, mk_res(0, 0, 0), LINE_LEN, 0);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("ovr_valid",   64'(res_valid),   64'd1);
    chk("ovr_maxval",  64'(res_maxval),  64'd80);
    chk("ovr_maxpos",  64'(res_maxpos),  64'd52);
    chk("ovr_found",   64'(res_found),   64'd1);
    chk("ovr_overrun", 64'(res_overrun), 64'd1);
    tick();
    res_ready = 1'b1;
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("ovr_once_valid", 64'(res_valid), 64'd0);
    chk("ovr_once_queue", 64'(exp_q.size()), 64'd0);
    tick();

    // Line aborted at pixel 40 by a fresh sol; only the second line reports.
    coef_line = C_FF;
    thr_line  = 20'd0;
    fill_line(1, 0, 255);
    send_line(1'b0, mk_res(0, 0, 0), 40, 0);
    coef_line = C_RAMP;
    thr_line  = ACC_W'($urandom_range(5000, 15000));
    fill_line(2, 0, 0);
    e = model();
    send_line(1'b1, e, LINE_LEN, 0);
    check_latency("abort");
    tick();
    tick();
    @(negedge clk);
    chk("abort_valid", 64'(res_valid), 64'd0);
    chk("abort_queue", 64'(exp_q.size()), 64'd0);
    chk("ovr_sticky",  64'(res_overrun), 64'd1);
    tick();

    // Reset pulsed at pixel 70.
    coef_line = C_ONES;
    thr_line  = 20'd1;
    fill_line(2, 0, 0);
    send_line(1'b0, mk_res(0, 0, 0), 71, 0);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    @(negedge clk);
    chk_outputs_zero("postreset_idle");
    tick();
    coef_line = {$urandom, $urandom};
    thr_line  = ACC_W'($urandom_range(150000, 350000));
    fill_line(2, 0, 0);
    e = model();
    send_line(1'b1, e, LINE_LEN, 0);
    check_latency("postreset");
    tick();
    tick();

    chk("final_queue", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
